// File: rtl/cpu_state_dumper_pkg.sv
// cpu_state_dumper_pkg: frame layout constants and FSM state type for the state dumper
package cpu_state_dumper_pkg;
  localparam logic [31:0] FRAME_MAGIC = 32'hC0DE_0000;
  localparam int unsigned HDR_LEN = 5;
  localparam int unsigned REG_COUNT = 32;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
endpackage

// File: rtl/cpu_state_dumper_perf_counters.sv
// cpu_state_dumper_perf_counters: cycle/stall/flush counters and snapshot registers taken at dump accept
module cpu_state_dumper_perf_counters
  import cpu_state_dumper_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        flush_i,
  input  logic        snap,
  input  logic [31:0] pc_i,
  output logic [31:0] cyc_s,
  output logic [31:0] pc_s,
  output logic [31:0] stall_s,
  output logic [31:0] flush_s
);
  logic [CNT_W-1:0] cyc, stl, fl;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cyc <= '0;
      stl <= '0;
      fl <= '0;
      cyc_s <= '0;
      pc_s <= '0;
      stall_s <= '0;
      flush_s <= '0;
    end else begin
      if (en) begin
        cyc <= cyc + CNT_W'(1);
        if (stall_i && !branch_i) stl <= stl + CNT_W'(1);
        if (flush_i) fl <= fl + CNT_W'(1);
      end
      // snapshot sees pre-increment values of the accept cycle
      if (snap) begin
        cyc_s <= 32'(cyc);
        pc_s <= pc_i;
        stall_s <= 32'(stl);
        flush_s <= 32'(fl);
      end
    end
endmodule

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: freezes the CPU and streams counters, registers and data memory as one frame
module cpu_state_dumper
  import cpu_state_dumper_pkg::*;
#(
  parameter int NUM_MEM_WORDS = 8,
  parameter int CNT_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        flush_i,
  input  logic        dump_req_i,
  output logic        freeze_o,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [4:0]  dmem_addr_o,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dout_o,
  output logic        dout_valid_o,
  output logic        dout_last_o,
  input  logic        dout_ready_i,
  output logic        busy_o
);
  localparam int unsigned LAST = HDR_LEN + REG_COUNT + NUM_MEM_WORDS - 1;
  localparam int IW = $clog2(LAST + 1);
  state_t state, state_d;
  logic [IW-1:0] idx;
  logic last_q, accept, hs;
  logic [31:0] word, cyc_s, pc_s, stall_s, flush_s;
  int unsigned k, nk;
  assign accept = state == IDLE && dump_req_i;
  assign hs = state == SEND && dout_ready_i;
  assign k = 32'(idx);
  assign nk = k + 1;
  assign busy_o = state != IDLE;
  assign freeze_o = busy_o;
  assign dout_valid_o = state == SEND;
  assign dout_last_o = last_q && state == SEND;
  cpu_state_dumper_perf_counters #(.CNT_W(CNT_W)) u_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en(run_i && !freeze_o),
    .stall_i(stall_i),
    .branch_i(branch_i),
    .flush_i(flush_i),
    .snap(accept),
    .pc_i(pc_i),
    .cyc_s(cyc_s),
    .pc_s(pc_s),
    .stall_s(stall_s),
    .flush_s(flush_s)
  );
  assign word = k == 0 ? FRAME_MAGIC | 32'(NUM_MEM_WORDS)
              : k == 1 ? cyc_s
              : k == 2 ? pc_s
              : k == 3 ? stall_s
              : k == 4 ? flush_s
              : k < HDR_LEN + REG_COUNT ? reg_data_i
              : dmem_data_i;
  always_comb
    state_d = state == IDLE ? (dump_req_i ? LOAD : IDLE)
            : state == LOAD ? SEND
            : dout_ready_i ? (last_q ? IDLE : LOAD) : SEND;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      idx <= '0;
      last_q <= 1'b0;
      dout_o <= '0;
      reg_addr_o <= '0;
      dmem_addr_o <= '0;
    end else begin
      state <= state_d;
      if (accept) idx <= '0;
      if (state == LOAD) begin
        dout_o <= word;
        last_q <= k == LAST;
      end
      // addresses are set up on the handshake so they are valid throughout the next LOAD
      if (hs) begin
        idx <= idx + IW'(1);
        if (!last_q && nk >= HDR_LEN && nk < HDR_LEN + REG_COUNT) reg_addr_o <= 5'(nk - HDR_LEN);
        if (!last_q && nk >= HDR_LEN + REG_COUNT) dmem_addr_o <= 5'(nk - HDR_LEN - REG_COUNT);
      end
    end
endmodule

// File: tb/tb_cpu_state_dumper.sv
// tb_cpu_state_dumper: frame-queue model of the dumper plus directed checks of counting, framing, backpressure, reset and wrap
module tb_cpu_state_dumper;
  logic clk_i = 0, rst_i = 0, run_i = 0, stall_i = 0, branch_i = 0, flush_i = 0, dump_req_i = 0;
  logic dout_ready_i;
  logic [31:0] pc_i = 0;
  logic freeze_o, busy_o, dout_valid_o, dout_last_o;
  logic [4:0] reg_addr_o, dmem_addr_o;
  logic [31:0] dout_o, reg_data_i, dmem_data_i;
  logic [31:0] regs[32], dmem[32];
  logic run4 = 0, req4 = 0, ready4 = 1;
  logic f4, b4, v4, l4;
  logic [4:0] ra4, da4;
  logic [31:0] d4, rd4, md4;
  int rdy_mode = 0;
  int total = 0, bad = 0;

  assign reg_data_i = regs[reg_addr_o];
  assign dmem_data_i = dmem[dmem_addr_o];
  assign rd4 = regs[ra4];
  assign md4 = dmem[da4];

  cpu_state_dumper #(.NUM_MEM_WORDS(8), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .pc_i(pc_i), .stall_i(stall_i),
    .branch_i(branch_i), .flush_i(flush_i), .dump_req_i(dump_req_i), .freeze_o(freeze_o),
    .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i), .dmem_addr_o(dmem_addr_o),
    .dmem_data_i(dmem_data_i), .dout_o(dout_o), .dout_valid_o(dout_valid_o),
    .dout_last_o(dout_last_o), .dout_ready_i(dout_ready_i), .busy_o(busy_o)
  );

  cpu_state_dumper #(.NUM_MEM_WORDS(8), .CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run4), .pc_i(pc_i), .stall_i(1'b0),
    .branch_i(1'b0), .flush_i(1'b0), .dump_req_i(req4), .freeze_o(f4),
    .reg_addr_o(ra4), .reg_data_i(rd4), .dmem_addr_o(da4),
    .dmem_data_i(md4), .dout_o(d4), .dout_valid_o(v4),
    .dout_last_o(l4), .dout_ready_i(ready4), .busy_o(b4)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i)
    dout_ready_i = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 99) < 30) : 1'b0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // model: a dump is the queue of words the frame must contain, built from spec-level counters
  logic [31:0] q[$];
  bit m_busy, was, hold, hold_l;
  logic [31:0] hold_d;
  int unsigned m_cyc, m_stl, m_fl;
  logic [31:0] fr[0:63], w4[0:63];
  int fr_n = 0, frames = 0, n4 = 0;

  always @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      q.delete();
      m_busy = 0;
      m_cyc = 0;
      m_stl = 0;
      m_fl = 0;
      hold = 0;
    end else begin
      was = m_busy;
      if (!was && dump_req_i) begin
        q.delete();
        q.push_back(32'hC0DE_0000 + 8);
        q.push_back(m_cyc);
        q.push_back(pc_i);
        q.push_back(m_stl);
        q.push_back(m_fl);
        for (int i = 0; i < 32; i++) q.push_back(regs[i]);
        for (int i = 0; i < 8; i++) q.push_back(dmem[i]);
        m_busy = 1;
        fr_n = 0;
      end
      if (run_i && !was) begin
        m_cyc++;
        if (stall_i && !branch_i) m_stl++;
        if (flush_i) m_fl++;
      end
      hold = dout_valid_o && !dout_ready_i;
      hold_d = dout_o;
      hold_l = dout_last_o;
      if (dout_valid_o && dout_ready_i) begin
        if (fr_n < 64) fr[fr_n] = dout_o;
        fr_n++;
        if (q.size() > 0) void'(q.pop_front());
        if (q.size() == 0 && m_busy) begin
          m_busy = 0;
          frames++;
        end
      end
    end

  always @(posedge clk_i or negedge rst_i)
    if (!rst_i) n4 = 0;
    else if (v4 && ready4) begin
      if (n4 < 64) w4[n4] = d4;
      n4++;
    end

  always @(negedge clk_i)
    if (rst_i) begin
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("freeze", 32'(freeze_o), 32'(m_busy));
      if (dout_valid_o) begin
        if (q.size() == 0) chk("valid_without_frame", 32'(dout_valid_o), 0);
        else begin
          chk("dout", dout_o, q[0]);
          chk("last", 32'(dout_last_o), 32'(q.size() == 1));
        end
      end
      if (hold) begin
        chk("valid_held", 32'(dout_valid_o), 1);
        chk("dout_held", dout_o, hold_d);
        chk("last_held", 32'(dout_last_o), 32'(hold_l));
      end
    end

  task automatic pulse_req();
    @(negedge clk_i) dump_req_i = 1;
    @(negedge clk_i) dump_req_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk_i);
    while ((busy_o || m_busy) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("idle_timeout", 32'(busy_o || m_busy), 0);
  endtask

  task automatic wait_words(int w);
    int n = 0;
    while (fr_n < w && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("words_timeout", 32'(fr_n >= w), 1);
  endtask

  initial begin
    int n, base;
    logic [31:0] w1a;
    for (int i = 0; i < 32; i++) begin
      regs[i] = i == 0 ? 0 : 32'(i * 7 + 3);
      dmem[i] = 32'(i * 11 + 1);
    end
    for (int i = 0; i < 4; i++) regs[24 + i] = -32'(24 + i);
    for (int i = 0; i < 4; i++) regs[28 + i] = 32'(56 + 2 * i);
    dmem[0] = 5; dmem[1] = 6; dmem[2] = 10; dmem[3] = 18; dmem[4] = 29;
    #2;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_freeze", 32'(freeze_o), 0);
    chk("rst_valid", 32'(dout_valid_o), 0);
    chk("rst_last", 32'(dout_last_o), 0);
    chk("rst_dout", dout_o, 0);
    chk("rst_addr", 32'({reg_addr_o, dmem_addr_o}), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    // 20 running cycles: stalls on 3 cycles (one masked by branch), flushes on 2
    run_i = 1;
    for (int c = 0; c < 20; c++) begin
      stall_i = c == 3 || c == 7 || c == 11;
      branch_i = c == 11;
      flush_i = c == 5 || c == 9;
      pc_i = 32'h40 + 32'(4 * c);
      @(negedge clk_i);
    end
    run_i = 0; stall_i = 0; branch_i = 0; flush_i = 0;
    pulse_req();
    wait_idle();
    chk("frame_len", fr_n, 45);
    chk("w0_magic", fr[0], 32'hC0DE_0008);
    chk("w1_cycle", fr[1], 20);
    chk("w2_pc", fr[2], 32'h8C);
    chk("w3_stall", fr[3], 2);
    chk("w4_flush", fr[4], 2);
    chk("w5_x0", fr[5], 0);
    chk("w29_x24", fr[29], 32'hFFFF_FFE8);
    chk("w36_x31", fr[36], 62);
    chk("w41_dmem4", fr[41], 29);
    // backpressure
    rdy_mode = 1;
    pulse_req();
    wait_idle();
    rdy_mode = 0;
    chk("bp_frame_len", fr_n, 45);
    chk("bp_w1", fr[1], 20);
    chk("bp_w29", fr[29], 32'hFFFF_FFE8);
    // request while busy is ignored; CPU frozen so count stays at accept value + 1
    base = frames;
    @(negedge clk_i) begin run_i = 1; dump_req_i = 1; end
    @(negedge clk_i) dump_req_i = 0;
    wait_words(10);
    pulse_req();
    wait_idle();
    run_i = 0;
    chk("ignored_frames", frames - base, 1);
    chk("busy_w1", fr[1], 20);
    // held request: back-to-back frames
    base = frames;
    run_i = 1;
    dump_req_i = 1;
    n = 0;
    while (frames < base + 1 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    w1a = fr[1];
    n = 0;
    while (!busy_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    dump_req_i = 0;
    run_i = 0;
    wait_idle();
    chk("b2b_frames", frames - base, 2);
    chk("b2b_w1_first", w1a, 21);
    chk("b2b_w1_second", fr[1], 22);
    // reset in the middle of a frame
    pulse_req();
    wait_words(10);
    #2 rst_i = 0;
    #1;
    chk("mid_rst_valid", 32'(dout_valid_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_freeze", 32'(freeze_o), 0);
    @(negedge clk_i) rst_i = 1;
    run_i = 1;
    repeat (5) @(negedge clk_i);
    run_i = 0;
    pulse_req();
    wait_idle();
    chk("post_rst_w1", fr[1], 5);
    chk("post_rst_w3", fr[3], 0);
    // 4-bit counters wrap: 17 cycles -> 1
    run4 = 1;
    repeat (17) @(negedge clk_i);
    run4 = 0;
    @(negedge clk_i) req4 = 1;
    @(negedge clk_i) req4 = 0;
    n = 0;
    while ((b4 || n4 == 0) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("wrap_len", n4, 45);
    chk("wrap_w0", w4[0], 32'hC0DE_0008);
    chk("wrap_w1", w4[1], 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
